// File: rtl/exec_sequencer_pkg.sv
// Shared types for the execution sequencer: FSM state encoding, fault codes and width helpers.
package exec_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_SEL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam int unsigned W_CNT = 32;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exec_sequencer_onehot_enc.sv
// One-hot to binary index encoder; valid_c is set only when exactly one bit is high.
module onehot_enc
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned W_IDX   = idx_width(N_UNITS)
) (
  input  logic [N_UNITS-1:0] onehot,
  output logic [W_IDX-1:0]   idx_c,
  output logic               valid_c
);

  localparam int unsigned W_POP = $clog2(N_UNITS + 1);

  logic [W_POP-1:0] pop;

  always_comb begin
    idx_c = '0;
    pop   = '0;
    for (int k = 0; k < int'(N_UNITS); k++) begin
      if (onehot[k]) begin
        idx_c = idx_c | W_IDX'(k);
        pop   = pop + W_POP'(1);
      end
    end
    valid_c = (pop == W_POP'(1));
  end

endmodule

// File: rtl/exec_sequencer.sv
// Issues one operation at a time to a selected functional unit, waits for its
// result with a timeout, and emits a single-cycle writeback.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned W_WORD  = 32,
  parameter int unsigned W_RD    = 6,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_UNITS-1:0]          in_unit,
  input  logic [W_WORD-1:0]           in_d1,
  input  logic [W_WORD-1:0]           in_d2,
  input  logic [W_RD-1:0]             in_rd,
  input  logic                        in_wb,
  output logic [N_UNITS-1:0]          u_order,
  input  logic [N_UNITS-1:0]          u_accepted,
  input  logic [N_UNITS-1:0]          u_done,
  input  logic [N_UNITS*W_WORD-1:0]   u_result,
  output logic [W_WORD-1:0]           u_d1,
  output logic [W_WORD-1:0]           u_d2,
  output logic                        wb_valid,
  output logic                        wb_en,
  output logic [W_RD-1:0]             wb_rd,
  output logic [W_WORD-1:0]           wb_data,
  output logic                        err,
  output logic [1:0]                  err_code,
  input  logic                        err_clr,
  output logic [W_CNT-1:0]            issue_cnt,
  output logic [W_CNT-1:0]            busy_cnt
);

  localparam int unsigned W_IDX = idx_width(N_UNITS);
  localparam int unsigned W_TO  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e               state, state_next;
  logic [W_IDX-1:0]     unit_idx, unit_idx_d;
  logic [W_RD-1:0]      rd_q, rd_d;
  logic                 wb_q, wb_d;
  logic [W_TO-1:0]      wait_cnt, wait_cnt_d;
  logic [N_UNITS-1:0]   u_order_d;
  logic [W_WORD-1:0]    u_d1_d, u_d2_d, wb_data_d;
  logic [W_RD-1:0]      wb_rd_d;
  logic                 wb_valid_d, wb_en_d, in_ready_d, err_d;
  logic [1:0]           err_code_d;
  logic [W_CNT-1:0]     issue_cnt_d, busy_cnt_d;

  logic [W_IDX-1:0]     in_idx_c;
  logic                 in_sel_ok_c;
  logic                 sel_acc_c, sel_done_c;
  logic [W_WORD-1:0]    sel_result_c;

  onehot_enc #(
    .N_UNITS (N_UNITS),
    .W_IDX   (W_IDX)
  ) u_enc (
    .onehot  (in_unit),
    .idx_c   (in_idx_c),
    .valid_c (in_sel_ok_c)
  );

  // Only the latched unit's handshake and result lanes are observed.
  always_comb begin
    sel_acc_c    = 1'b0;
    sel_done_c   = 1'b0;
    sel_result_c = '0;
    for (int k = 0; k < int'(N_UNITS); k++) begin
      if (unit_idx == W_IDX'(k)) begin
        sel_acc_c    = u_accepted[k];
        sel_done_c   = u_done[k];
        sel_result_c = u_result[k*int'(W_WORD) +: W_WORD];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      unit_idx  <= '0;
      rd_q      <= '0;
      wb_q      <= 1'b0;
      wait_cnt  <= '0;
      u_order   <= '0;
      u_d1      <= '0;
      u_d2      <= '0;
      wb_valid  <= 1'b0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      in_ready  <= 1'b1;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      issue_cnt <= '0;
      busy_cnt  <= '0;
    end else begin
      state     <= state_next;
      unit_idx  <= unit_idx_d;
      rd_q      <= rd_d;
      wb_q      <= wb_d;
      wait_cnt  <= wait_cnt_d;
      u_order   <= u_order_d;
      u_d1      <= u_d1_d;
      u_d2      <= u_d2_d;
      wb_valid  <= wb_valid_d;
      wb_en     <= wb_en_d;
      wb_rd     <= wb_rd_d;
      wb_data   <= wb_data_d;
      in_ready  <= in_ready_d;
      err       <= err_d;
      err_code  <= err_code_d;
      issue_cnt <= issue_cnt_d;
      busy_cnt  <= busy_cnt_d;
    end
  end

  always_comb begin
    state_next  = state;
    unit_idx_d  = unit_idx;
    rd_d        = rd_q;
    wb_d        = wb_q;
    wait_cnt_d  = wait_cnt;
    u_order_d   = u_order;
    u_d1_d      = u_d1;
    u_d2_d      = u_d2;
    wb_valid_d  = 1'b0;
    wb_en_d     = 1'b0;
    wb_rd_d     = wb_rd;
    wb_data_d   = wb_data;
    err_code_d  = err_code;
    issue_cnt_d = issue_cnt;
    busy_cnt_d  = busy_cnt;

    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_sel_ok_c) begin
            unit_idx_d  = in_idx_c;
            rd_d        = in_rd;
            wb_d        = in_wb;
            u_d1_d      = in_d1;
            u_d2_d      = in_d2;
            u_order_d   = in_unit;
            wait_cnt_d  = '0;
            issue_cnt_d = issue_cnt + W_CNT'(1);
            state_next  = ST_WAIT;
          end else begin
            err_code_d = ERR_BAD_SEL;
            state_next = ST_ERR;
          end
        end
      end
      ST_WAIT: begin
        busy_cnt_d = busy_cnt + W_CNT'(1);
        wait_cnt_d = wait_cnt + W_TO'(1);
        // Done outranks the timeout when both land in the same cycle.
        if (sel_done_c) begin
          u_order_d  = '0;
          wb_data_d  = sel_result_c;
          wb_valid_d = 1'b1;
          wb_en_d    = wb_q;
          wb_rd_d    = rd_q;
          state_next = ST_WRITE;
        end else if (wait_cnt == W_TO'(TIMEOUT - 1)) begin
          u_order_d  = '0;
          err_code_d = ERR_TIMEOUT;
          state_next = ST_ERR;
        end else if (sel_acc_c) begin
          u_order_d = '0;
        end
      end
      ST_WRITE: begin
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        if (err_clr) begin
          err_code_d = ERR_NONE;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    in_ready_d = (state_next == ST_IDLE);
    err_d      = (state_next == ST_ERR);
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: issue/writeback timing, bad select,
// timeout and its race with done, and reset in the middle of WAIT.
module tb_exec_sequencer;

  localparam int unsigned N_UNITS = 4;
  localparam int unsigned W_WORD  = 32;
  localparam int unsigned W_RD    = 6;
  localparam int unsigned TIMEOUT = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [N_UNITS-1:0]        in_unit;
  logic [W_WORD-1:0]         in_d1, in_d2;
  logic [W_RD-1:0]           in_rd;
  logic                      in_wb;
  logic [N_UNITS-1:0]        u_order;
  logic [N_UNITS-1:0]        u_accepted, u_done;
  logic [N_UNITS*W_WORD-1:0] u_result;
  logic [W_WORD-1:0]         u_d1, u_d2;
  logic                      wb_valid, wb_en;
  logic [W_RD-1:0]           wb_rd;
  logic [W_WORD-1:0]         wb_data;
  logic                      err;
  logic [1:0]                err_code;
  logic                      err_clr;
  logic [31:0]               issue_cnt, busy_cnt;

  int errors = 0;
  int checks = 0;

  exec_sequencer #(
    .N_UNITS (N_UNITS),
    .W_WORD  (W_WORD),
    .W_RD    (W_RD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_unit    (in_unit),
    .in_d1      (in_d1),
    .in_d2      (in_d2),
    .in_rd      (in_rd),
    .in_wb      (in_wb),
    .u_order    (u_order),
    .u_accepted (u_accepted),
    .u_done     (u_done),
    .u_result   (u_result),
    .u_d1       (u_d1),
    .u_d2       (u_d2),
    .wb_valid   (wb_valid),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .err        (err),
    .err_code   (err_code),
    .err_clr    (err_clr),
    .issue_cnt  (issue_cnt),
    .busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_result(input int unit, input logic [W_WORD-1:0] val);
    u_result[unit*int'(W_WORD) +: W_WORD] = val;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_unit = '0; in_d1 = '0; in_d2 = '0;
    in_rd = '0; in_wb = 1'b0; u_accepted = '0; u_done = '0; u_result = '0;
    err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_u_order", 64'(u_order), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_issue_cnt", 64'(issue_cnt), 64'd0);
    check("rst_busy_cnt", 64'(busy_cnt), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);

    // Unit 2: accepted at +2, done at +4, result 12
    in_valid = 1'b1; in_unit = 4'b0100; in_d1 = 32'd5; in_d2 = 32'd7; in_rd = 6'd3; in_wb = 1'b1;
    tick();
    in_valid = 1'b0; in_d1 = 32'hFFFF_FFFF; in_d2 = '0;
    check("t1_order_c1", 64'(u_order), 64'h4);
    check("t1_ready_c1", 64'(in_ready), 64'd0);
    check("t1_issue", 64'(issue_cnt), 64'd1);
    check("t1_d1", 64'(u_d1), 64'd5);
    check("t1_d2", 64'(u_d2), 64'd7);
    u_accepted = 4'b0001; u_done = 4'b0001; set_result(0, 32'h99);
    tick();
    u_accepted = '0; u_done = '0;
    check("t1_order_c2", 64'(u_order), 64'h4);
    check("t1_foreign_done", 64'(wb_valid), 64'd0);
    u_accepted = 4'b0100;
    tick();
    u_accepted = '0;
    check("t1_order_c3", 64'(u_order), 64'h0);
    tick();
    u_done = 4'b0100; set_result(2, 32'd12);
    tick();
    u_done = '0;
    check("t1_wb_valid", 64'(wb_valid), 64'd1);
    check("t1_wb_en", 64'(wb_en), 64'd1);
    check("t1_wb_rd", 64'(wb_rd), 64'd3);
    check("t1_wb_data", 64'(wb_data), 64'd12);
    check("t1_busy", 64'(busy_cnt), 64'd4);
    check("t1_ready_in_write", 64'(in_ready), 64'd0);
    tick();
    check("t1_wb_valid_drop", 64'(wb_valid), 64'd0);
    check("t1_ready_back", 64'(in_ready), 64'd1);
    check("t1_d1_stable", 64'(u_d1), 64'd5);

    // Unit 0: accepted and done in the first WAIT cycle
    in_valid = 1'b1; in_unit = 4'b0001; in_d1 = 32'd1; in_d2 = 32'd2; in_rd = 6'd5; in_wb = 1'b0;
    tick();
    in_valid = 1'b0;
    u_accepted = 4'b0001; u_done = 4'b0001; set_result(0, 32'hDEAD_BEEF);
    tick();
    u_accepted = '0; u_done = '0;
    check("t2_wb_valid", 64'(wb_valid), 64'd1);
    check("t2_wb_data", 64'(wb_data), 64'hDEAD_BEEF);
    check("t2_wb_en", 64'(wb_en), 64'd0);
    check("t2_wb_rd", 64'(wb_rd), 64'd5);
    check("t2_order", 64'(u_order), 64'd0);
    check("t2_issue", 64'(issue_cnt), 64'd2);
    check("t2_busy", 64'(busy_cnt), 64'd5);
    tick();
    check("t2_ready_c3", 64'(in_ready), 64'd1);
    check("t2_wb_valid_drop", 64'(wb_valid), 64'd0);

    // Bad select: two bits set
    in_valid = 1'b1; in_unit = 4'b0110;
    tick();
    in_valid = 1'b0; in_unit = '0;
    check("t3_err", 64'(err), 64'd1);
    check("t3_err_code", 64'(err_code), 64'd1);
    check("t3_order", 64'(u_order), 64'd0);
    check("t3_ready", 64'(in_ready), 64'd0);
    check("t3_issue", 64'(issue_cnt), 64'd2);
    tick();
    check("t3_err_hold", 64'(err), 64'd1);
    err_clr = 1'b1;
    tick();
    check("t3_clr_err", 64'(err), 64'd0);
    check("t3_clr_code", 64'(err_code), 64'd0);
    check("t3_clr_ready", 64'(in_ready), 64'd1);
    tick();
    err_clr = 1'b0;
    check("t3_clr_idle_noop", 64'(in_ready), 64'd1);

    // Timeout on unit 1 with responses only on other lanes
    in_valid = 1'b1; in_unit = 4'b0010; in_d1 = 32'hA5; in_d2 = 32'h5A; in_rd = 6'd9; in_wb = 1'b1;
    tick();
    in_valid = 1'b0;
    u_accepted = 4'b1101; u_done = 4'b1101;
    for (int i = 0; i < 7; i++) tick();
    check("t4_order_c8", 64'(u_order), 64'h2);
    check("t4_err_c8", 64'(err), 64'd0);
    tick();
    check("t4_err", 64'(err), 64'd1);
    check("t4_err_code", 64'(err_code), 64'd2);
    check("t4_order", 64'(u_order), 64'd0);
    check("t4_wb_valid", 64'(wb_valid), 64'd0);
    check("t4_busy", 64'(busy_cnt), 64'd13);
    check("t4_d1_stable", 64'(u_d1), 64'hA5);
    u_accepted = '0; u_done = '0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_clr_ready", 64'(in_ready), 64'd1);

    // Done in the last WAIT cycle beats the timeout
    in_valid = 1'b1; in_unit = 4'b1000; in_rd = 6'd17; in_wb = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    u_done = 4'b1000; set_result(3, 32'h1234_5678);
    tick();
    u_done = '0;
    check("t5_race_wb_valid", 64'(wb_valid), 64'd1);
    check("t5_race_err", 64'(err), 64'd0);
    check("t5_race_data", 64'(wb_data), 64'h1234_5678);
    check("t5_race_busy", 64'(busy_cnt), 64'd21);
    tick();

    // Reset in the middle of WAIT
    in_valid = 1'b1; in_unit = 4'b1000; in_d1 = 32'h77; in_d2 = 32'h88;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_order", 64'(u_order), 64'd0);
    check("t6_ready", 64'(in_ready), 64'd1);
    check("t6_issue", 64'(issue_cnt), 64'd0);
    check("t6_busy", 64'(busy_cnt), 64'd0);
    check("t6_wb_data", 64'(wb_data), 64'd0);
    check("t6_d1", 64'(u_d1), 64'd0);
    check("t6_wb_rd", 64'(wb_rd), 64'd0);
    u_done = 4'b1000; u_accepted = 4'b1000; set_result(3, 32'hCAFE);
    tick();
    check("t6_late_done_1", 64'(wb_valid), 64'd0);
    tick();
    u_done = '0; u_accepted = '0;
    check("t6_late_done_2", 64'(wb_valid), 64'd0);
    check("t6_late_err", 64'(err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter N_UNITS, default 4; number of functional-unit channels (1..16).
REQ-002 SHALL have parameter W_WORD, default 32; operand/result width.
REQ-003 SHALL have parameter W_RD, default 6; destination register address width.
REQ-004 SHALL have parameter TIMEOUT, default 1024; maximum cycles in WAIT before a fault.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-006 Ports:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  in_valid  in  1  operation offered
  in_ready  out  1  sequencer can accept
  in_unit  in  N_UNITS  one-hot target unit
  in_d1, in_d2  in  W_WORD  operands
  in_rd  in  W_RD  destination register
  in_wb  in  1  result is written back
  u_order  out  N_UNITS  per-unit order
  u_accepted  in  N_UNITS  per-unit accepted
  u_done  in  N_UNITS  per-unit done
  u_result  in  N_UNITS*W_WORD  packed results, unit k at [k*W_WORD +: W_WORD]
  u_d1, u_d2  out  W_WORD  latched operands broadcast to all units
  wb_valid  out  1  one-cycle writeback strobe
  wb_en, wb_rd, wb_data  out  1/W_RD/W_WORD  writeback enable, address, data
  err  out  1  fault latched
  err_code  out  2  0 none, 1 bad select, 2 timeout
  err_clr  in  1  clears fault
  issue_cnt, busy_cnt  out  32  operations issued; cycles spent in WAIT

Function
REQ-007 States SHALL be IDLE, WAIT, WRITE, ERR.
REQ-008 in_ready SHALL be 1 only in IDLE.
REQ-009 In IDLE with in_valid=1 and popcount(in_unit)=1, the sequencer SHALL latch operands, rd, wb and unit index, set u_order[k]=1 on the next edge, increment issue_cnt, and enter WAIT.
REQ-010 In IDLE with in_valid=1 and popcount(in_unit)!=1, it SHALL enter ERR with err_code=1 and issue nothing.
REQ-011 At most one u_order bit SHALL be high at any time.
REQ-012 In WAIT, u_order[k] SHALL drop on the edge after u_accepted[k]=1 or u_done[k]=1, whichever comes first.
REQ-013 In WAIT, u_done[k]=1 SHALL capture u_result slice k into wb_data and enter WRITE; accepted and done in the same cycle is legal.
REQ-014 u_accepted and u_done bits of non-selected units SHALL be ignored.
REQ-015 A WAIT counter SHALL clear on entry; when it reaches TIMEOUT-1 without done, the sequencer SHALL drop u_order, set err_code=2, and enter ERR. Done in that same cycle SHALL win.
REQ-016 busy_cnt SHALL increment every cycle in WAIT; both counters SHALL wrap modulo 2^32.
REQ-017 WRITE SHALL last exactly one cycle: wb_valid=1, wb_en=latched in_wb, wb_rd=latched rd; it then returns to IDLE. There is no writeback backpressure.
REQ-018 Minimum latency SHALL be: handshake at cycle 0, done sampled at cycle 1, wb_valid at cycle 2, in_ready at cycle 3.
REQ-019 ERR SHALL hold err=1 and in_ready=0 until err_clr=1, then return to IDLE with err_code=0. err_clr outside ERR SHALL have no effect.
REQ-020 u_d1/u_d2 SHALL stay stable from issue until the next issue.

Reset
REQ-021 rst SHALL force IDLE and set u_order=0, wb_valid=0, wb_en=0, wb_rd=0, wb_data=0, u_d1=u_d2=0, err=0, err_code=0, issue_cnt=0, busy_cnt=0.
REQ-022 rst asserted during WAIT SHALL drop u_order on the same edge; late unit responses after reset SHALL be ignored.

Structure
REQ-023 The state encodings and the err_code values 0/1/2 SHALL be defined in the shared include file.
REQ-024 One-hot-to-index conversion with a validity flag SHALL be a sub-module, onehot_enc, parameterised by N_UNITS.

Verification
REQ-025 N_UNITS=4: issue in_unit=4'b0100, d1=5, d2=7, rd=3, wb=1; unit 2 asserts accepted at +2 and done at +4 with result 12 -> u_order[2] is high for 2 cycles; wb_valid one cycle with wb_rd=3, wb_data=12; issue_cnt=1; busy_cnt=4.
REQ-026 Unit 0 asserts accepted and done in the first WAIT cycle, result 0xDEADBEEF -> wb_valid at cycle 2 with wb_data=0xDEADBEEF; in_ready high again at cycle 3.
REQ-027 in_unit=4'b0110 -> ERR, err_code=1, no u_order bit set; err_clr=1 -> IDLE, in_ready=1.
REQ-028 TIMEOUT=8, unit never responds -> after 8 WAIT cycles: err=1, err_code=2, u_order=0; unit 1 done asserted only in non-selected lanes never produces wb_valid.
REQ-029 rst pulsed in the middle of WAIT -> next cycle all outputs equal their reset values; a subsequent done pulse produces no wb_valid.
